exc_pipe_chain: RTL and testbench
=================================

# exc_pipe_chain

Parametrised multi-stage carrier for exception state, replacing the single-hop exception-code registers between pipeline stages. It moves each instruction's exception code, PC, branch-delay flag and valid bit from decode to the CP0 commit point. It merges exceptions detected in later stages so that the first exception detected stays attached to the instruction, and it honours per-stage stall and per-stage kill. It also supports the global flush on exception entry (ActivateCP0) and eret (CoolCP0).

## Interface
- STAGES, 3, number of register hops (legal 2..4); register k feeds stage k+1 (k=0 is D->E)
- CODE_W, 5, exception code width; code 0 means no exception
- PC_W, 32, PC width
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- ActivateCP0  in  1  exception taken; flush all stages
- CoolCP0  in  1  eret executed; flush all stages
- Vld_In  in  1  decode stage holds a real instruction
- ExcCode_In  in  CODE_W  exception code found by decode
- PC_In  in  PC_W  decode-stage PC
- BD_In  in  1  decode instruction is in a branch delay slot
- ExcDet  in  STAGES*CODE_W  slice k = code detected by the stage fed by register k
- Stall  in  STAGES  bit k: register k holds its contents
- Kill  in  STAGES  bit k: register k loads a bubble this edge
- ExcCode_Out  out  CODE_W  merged code at the commit stage
- PC_Out  out  PC_W  commit-stage PC
- BD_Out  out  1  commit-stage BD flag
- Vld_Out  out  1  commit stage holds a real instruction
- ExcPending  out  1  some valid stage carries a nonzero merged code
- ExcStage  out  2  lowest-index register holding such an entry; 0 when none

## Operation
- Each register k holds {Vld, Code, PC, BD}. A bubble is Vld=0, Code=0, BD=0, with PC held at its previous value.
- Merged code: M_k = Code_k if Code_k != 0. Otherwise M_k = ExcDet slice k if Vld_k = 1. Otherwise M_k = 0.
- The older (earlier-stage) exception always wins. A later ExcDet never overwrites a nonzero code.
- Next-state priority per register k, highest first:
  1. Rst, ActivateCP0 or CoolCP0: bubble.
  2. Kill[k]: bubble.
  3. Stall[k]: hold all fields. The merged code is not written back, and ExcDet is re-evaluated every cycle.
  4. Stall[k-1] for k>0: bubble. An upstream hold inserts a bubble downstream.
  5. Otherwise load from upstream. k=0 loads {Vld_In, ExcCode_In & {CODE_W{Vld_In}}, PC_In, BD_In & Vld_In}. k>0 loads {Vld_{k-1}, M_{k-1}, PC_{k-1}, BD_{k-1}}.
- Outputs:
  - ExcCode_Out = M_{STAGES-1} (combinational).
  - PC_Out, BD_Out and Vld_Out come from register STAGES-1 directly.
- ExcPending = OR over k of (Vld_k and M_k != 0). ExcStage is a priority encode from k=0 upward.
- ExcCode_In with Vld_In=0 is discarded.

## Timing
- After a Rst edge, all registers hold bubbles. PC fields reset to 0. All outputs are 0.
- Latency is STAGES edges from a decode-stage capture to Vld_Out with no stalls. Each stall cycle on any register adds 1.
- Flush via Rst, ActivateCP0 or CoolCP0 takes effect on the same edge and overrides Stall and Kill. The following cycle shows all outputs at 0 except PC_Out.
- ActivateCP0 and CoolCP0 asserted together behave as a single flush.
- Stall[k] and Kill[k] asserted together: Kill wins.
- If Stall[k-1] is held while register k drains, register k fills with a bubble every cycle until the stall releases. The held instruction advances on the first edge with Stall[k-1]=0.
- ExcDet and ExcCode_Out are a zero-latency path: CP0 samples ExcCode_Out in the same cycle the commit stage detects.

## Test plan
- **Basic flow:** STAGES=3. Apply Vld_In=1, ExcCode_In=0, PC_In=0x3000 at cycle 0, with no ExcDet. Expect Vld_Out=1, PC_Out=0x3000 and ExcCode_Out=0 after 3 edges, with ExcPending=0 throughout.
- **Older exception wins:** decode code 10 at PC 0x3004, then ExcDet slice 1 = 12 while that entry sits in register 1. Expect ExcCode_Out=10, never 12. While the entry sits in register 1, expect ExcPending=1 and ExcStage=1.
- **Late detection:** a clean entry sits in register 2 and ExcDet slice 2 = 4. Expect ExcCode_Out=4 combinationally in the same cycle. Expect ExcCode_Out=0 once that entry leaves.
- **Stall bubble:** assert Stall[0] for 2 cycles with a valid entry at 0x3008 in register 0. Expect register 1 to take 2 bubbles. Expect 0x3008 at Vld_Out exactly 2 cycles later than the unstalled case, with no duplication.
- **Flush priority:** fill all 3 stages with valid entries, then pulse ActivateCP0 together with Stall=3'b111. Expect all Vld=0, ExcPending=0 and ExcCode_Out=0 on the next cycle. Repeat with CoolCP0 and expect the same.
- **Kill vs stall and reset:** assert Kill[1] and Stall[1] together and expect register 1 to become a bubble. Then assert Rst mid-flow and expect all outputs 0, including PC_Out=0.

Source files
------------

// File: rtl/exc_pipe_chain.sv
// Purpose: carries per-instruction exception state (valid, code, PC, BD) from decode to CP0 commit,
//          merging later-stage detections so the oldest exception stays attached to the instruction.
// Latency: STAGES edges decode->commit; ExcDet -> ExcCode_Out and ExcPending/ExcStage are combinational.
// Backpressure: Stall[k] holds register k and inserts bubbles into k+1; Kill[k] loads a bubble;
//               flush (ActivateCP0/CoolCP0) and Rst override both.
// Ports: Clk/Rst (sync, active-high); ActivateCP0/CoolCP0 global flush; Vld_In/ExcCode_In/PC_In/BD_In
//        decode capture; ExcDet per-stage detected codes; Stall/Kill per-register control;
//        ExcCode_Out/PC_Out/BD_Out/Vld_Out commit view; ExcPending/ExcStage oldest pending exception.
module exc_pipe_chain #(
    parameter int STAGES = 3,
    parameter int CODE_W = 5,
    parameter int PC_W   = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       ActivateCP0,
    input  logic                       CoolCP0,
    input  logic                       Vld_In,
    input  logic [CODE_W-1:0]          ExcCode_In,
    input  logic [PC_W-1:0]            PC_In,
    input  logic                       BD_In,
    input  logic [STAGES*CODE_W-1:0]   ExcDet,
    input  logic [STAGES-1:0]          Stall,
    input  logic [STAGES-1:0]          Kill,
    output logic [CODE_W-1:0]          ExcCode_Out,
    output logic [PC_W-1:0]            PC_Out,
    output logic                       BD_Out,
    output logic                       Vld_Out,
    output logic                       ExcPending,
    output logic [1:0]                 ExcStage
);

    logic [STAGES-1:0]             vld_q, vld_d;
    logic [STAGES-1:0]             bd_q, bd_d;
    logic [STAGES-1:0][CODE_W-1:0] code_q, code_d;
    logic [STAGES-1:0][PC_W-1:0]   pc_q, pc_d;

    // Merged code per register: a stored (older) code always beats a fresh detection.
    logic [STAGES-1:0][CODE_W-1:0] merged;

    // What each register would load if it advanced; entry 0 is the decode capture.
    logic [STAGES-1:0]             up_vld, up_bd, up_stall;
    logic [STAGES-1:0][CODE_W-1:0] up_code;
    logic [STAGES-1:0][PC_W-1:0]   up_pc;

    logic flush;
    assign flush = ActivateCP0 | CoolCP0;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            merged[k] = '0;
            if (code_q[k] != '0)
                merged[k] = code_q[k];
            else if (vld_q[k])
                merged[k] = ExcDet[k*CODE_W +: CODE_W];
        end
    end

    always_comb begin
        up_vld[0]   = Vld_In;
        up_code[0]  = ExcCode_In & {CODE_W{Vld_In}};
        up_pc[0]    = PC_In;
        up_bd[0]    = BD_In & Vld_In;
        up_stall[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k]   = vld_q[k-1];
            up_code[k]  = merged[k-1];
            up_pc[k]    = pc_q[k-1];
            up_bd[k]    = bd_q[k-1];
            up_stall[k] = Stall[k-1];
        end
    end

    // Bubbles keep the PC so the commit-stage PC stays meaningful across gaps.
    always_comb begin
        vld_d  = vld_q;
        code_d = code_q;
        pc_d   = pc_q;
        bd_d   = bd_q;
        for (int k = 0; k < STAGES; k++) begin
            if (flush || Kill[k] || (!Stall[k] && up_stall[k])) begin
                vld_d[k]  = 1'b0;
                code_d[k] = '0;
                bd_d[k]   = 1'b0;
            end else if (!Stall[k]) begin
                vld_d[k]  = up_vld[k];
                code_d[k] = up_code[k];
                pc_d[k]   = up_pc[k];
                bd_d[k]   = up_bd[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_q  <= '0;
            code_q <= '0;
            pc_q   <= '0;
            bd_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            code_q <= code_d;
            pc_q   <= pc_d;
            bd_q   <= bd_d;
        end
    end

    assign ExcCode_Out = merged[STAGES-1];
    assign PC_Out      = pc_q[STAGES-1];
    assign BD_Out      = bd_q[STAGES-1];
    assign Vld_Out     = vld_q[STAGES-1];

    // Scan from the commit end back so the lowest index found is the one reported.
    always_comb begin
        ExcPending = 1'b0;
        ExcStage   = 2'd0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (vld_q[k] && (merged[k] != '0)) begin
                ExcPending = 1'b1;
                ExcStage   = 2'(k);
            end
        end
    end

endmodule

// File: tb/tb_exc_pipe_chain.sv
// Purpose: checks exc_pipe_chain against an entry-level model of the pipeline.
// Latency: model advances once per rising edge; outputs compared mid-cycle.
// Backpressure: stall/kill/flush exercised by directed sequences and random stimulus.
module tb_exc_pipe_chain;
    localparam int S  = 3;
    localparam int CW = 5;
    localparam int PW = 32;

    logic            Clk = 1'b0;
    logic            Rst, ActivateCP0, CoolCP0, Vld_In, BD_In;
    logic [CW-1:0]   ExcCode_In;
    logic [PW-1:0]   PC_In;
    logic [S*CW-1:0] ExcDet;
    logic [S-1:0]    Stall, Kill;
    logic [CW-1:0]   ExcCode_Out;
    logic [PW-1:0]   PC_Out;
    logic            BD_Out, Vld_Out, ExcPending;
    logic [1:0]      ExcStage;

    exc_pipe_chain #(.STAGES(S), .CODE_W(CW), .PC_W(PW)) dut (
        .Clk(Clk), .Rst(Rst), .ActivateCP0(ActivateCP0), .CoolCP0(CoolCP0),
        .Vld_In(Vld_In), .ExcCode_In(ExcCode_In), .PC_In(PC_In), .BD_In(BD_In),
        .ExcDet(ExcDet), .Stall(Stall), .Kill(Kill),
        .ExcCode_Out(ExcCode_Out), .PC_Out(PC_Out), .BD_Out(BD_Out), .Vld_Out(Vld_Out),
        .ExcPending(ExcPending), .ExcStage(ExcStage)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: one instruction record per pipeline slot.
    typedef struct {
        bit       vld;
        bit [4:0] code;
        bit [31:0] pc;
        bit       bd;
    } entry_t;
    entry_t slot [S];

    function automatic bit [4:0] det_of(int k);
        return ExcDet[k*CW +: CW];
    endfunction

    // Oldest exception wins: a recorded code is never replaced by a later detection.
    function automatic bit [4:0] eff_code(int k);
        if (slot[k].code != 0) return slot[k].code;
        if (slot[k].vld) return det_of(k);
        return 5'd0;
    endfunction

    function automatic entry_t bubble_of(entry_t e);
        entry_t b;
        b = e;
        b.vld = 0; b.code = 0; b.bd = 0;
        return b;
    endfunction

    task automatic model_edge();
        if (Rst) begin
            foreach (slot[k]) slot[k] = '{0, 0, 0, 0};
            return;
        end
        // Walk from the commit end so each slot reads its upstream neighbour's pre-edge value.
        for (int k = S - 1; k >= 0; k--) begin
            if (ActivateCP0 || CoolCP0 || Kill[k])
                slot[k] = bubble_of(slot[k]);
            else if (Stall[k])
                ;
            else if (k > 0 && Stall[k-1])
                slot[k] = bubble_of(slot[k]);
            else if (k == 0)
                slot[0] = '{Vld_In, Vld_In ? ExcCode_In : 5'd0, PC_In, BD_In && Vld_In};
            else begin
                entry_t up;
                up = slot[k-1];
                up.code = eff_code(k-1);
                slot[k] = up;
            end
        end
    endtask

    task automatic compare_outputs();
        bit       pend;
        bit [1:0] stg;
        pend = 0; stg = 0;
        for (int k = 0; k < S; k++)
            if (!pend && slot[k].vld && eff_code(k) != 0) begin
                pend = 1; stg = 2'(k);
            end
        chk("Vld_Out",     {31'd0, Vld_Out},    {31'd0, slot[S-1].vld});
        chk("PC_Out",      PC_Out,              slot[S-1].pc);
        chk("BD_Out",      {31'd0, BD_Out},     {31'd0, slot[S-1].bd});
        chk("ExcCode_Out", {27'd0, ExcCode_Out}, {27'd0, eff_code(S-1)});
        chk("ExcPending",  {31'd0, ExcPending}, {31'd0, pend});
        chk("ExcStage",    {30'd0, ExcStage},   {30'd0, stg});
    endtask

    // One clock: compare mid-cycle with the inputs already applied, then advance model.
    // Returns 2 time units after the edge so the caller can change inputs safely.
    task automatic tick(input bit do_cmp);
        @(negedge Clk);
        #1;
        if (do_cmp) compare_outputs();
        @(posedge Clk);
        model_edge();
        #2;
    endtask

    task automatic idle_inputs();
        Rst = 0; ActivateCP0 = 0; CoolCP0 = 0; Vld_In = 0; ExcCode_In = 0;
        BD_In = 0; ExcDet = 0; Stall = 0; Kill = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] code, input bit bd);
        idle_inputs();
        Vld_In = 1; PC_In = pc; ExcCode_In = code; BD_In = bd;
        tick(1);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        PC_In = 0;
        Rst = 1;
        tick(0);
        tick(0);
        idle_inputs();
        #1;
        chk("rst_vld",  {31'd0, Vld_Out}, 0);
        chk("rst_pc",   PC_Out, 0);
        chk("rst_code", {27'd0, ExcCode_Out}, 0);
        chk("rst_pend", {31'd0, ExcPending}, 0);

        // Basic flow: visible after 3 edges.
        push(32'h3000, 0, 0);
        tick(1); tick(1);
        chk("flow_vld", {31'd0, Vld_Out}, 1);
        chk("flow_pc",  PC_Out, 32'h3000);
        chk("flow_code", {27'd0, ExcCode_Out}, 0);

        // Older exception wins over a later detection.
        push(32'h3004, 5'd10, 1);
        tick(1);
        chk("old_pend",  {31'd0, ExcPending}, 1);
        chk("old_stage", {30'd0, ExcStage}, 1);
        ExcDet = 15'(12) << CW;
        tick(1);
        chk("old_code", {27'd0, ExcCode_Out}, 10);
        chk("old_bd",   {31'd0, BD_Out}, 1);
        idle_inputs();

        // Late detection at the commit stage is combinational.
        push(32'h300C, 0, 0);
        tick(1); tick(1);
        ExcDet = 15'(4) << (2 * CW);
        #1;
        chk("late_code", {27'd0, ExcCode_Out}, 4);
        tick(1);
        chk("late_gone", {27'd0, ExcCode_Out}, 0);
        idle_inputs();

        // Stall[0] for two cycles delays commit by exactly two cycles.
        push(32'h3008, 0, 0);
        Stall = 3'b001;
        tick(1); tick(1);
        Stall = 0;
        tick(1);
        chk("stall_early", {31'd0, Vld_Out}, 0);
        tick(1);
        chk("stall_vld", {31'd0, Vld_Out}, 1);
        chk("stall_pc",  PC_Out, 32'h3008);
        tick(1);
        chk("stall_nodup", {31'd0, Vld_Out}, 0);

        // Flush overrides stall, for both flush sources.
        for (int f = 0; f < 2; f++) begin
            push(32'h4000, 0, 0); push(32'h4004, 5'd3, 0); push(32'h4008, 0, 1);
            Stall = 3'b111;
            if (f == 0) ActivateCP0 = 1; else CoolCP0 = 1;
            tick(1);
            idle_inputs();
            #1;
            chk("flush_vld",  {31'd0, Vld_Out}, 0);
            chk("flush_pend", {31'd0, ExcPending}, 0);
            chk("flush_code", {27'd0, ExcCode_Out}, 0);
            chk("flush_bd",   {31'd0, BD_Out}, 0);
        end

        // Kill beats stall on register 1, then reset mid-flow.
        push(32'h5000, 0, 0); push(32'h5004, 5'd7, 0);
        Kill = 3'b010; Stall = 3'b010;
        tick(1);
        idle_inputs();
        tick(1);
        chk("kill_bubble", {31'd0, Vld_Out}, 0);
        push(32'h6000, 0, 1); push(32'h6004, 5'd2, 1);
        Rst = 1;
        tick(1);
        idle_inputs();
        #1;
        chk("rst2_vld",  {31'd0, Vld_Out}, 0);
        chk("rst2_pc",   PC_Out, 0);
        chk("rst2_code", {27'd0, ExcCode_Out}, 0);
        chk("rst2_pend", {31'd0, ExcPending}, 0);
        chk("rst2_stg",  {30'd0, ExcStage}, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            Rst         = ($urandom_range(0, 59) == 0);
            ActivateCP0 = ($urandom_range(0, 29) == 0);
            CoolCP0     = ($urandom_range(0, 29) == 0);
            Vld_In      = ($urandom_range(0, 3) != 0);
            ExcCode_In  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            PC_In       = $urandom;
            BD_In       = 1'($urandom);
            for (int k = 0; k < S; k++) begin
                ExcDet[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
                Stall[k] = ($urandom_range(0, 5) == 0);
                Kill[k]  = ($urandom_range(0, 9) == 0);
            end
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
